// File: rtl/memory_bus_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// memory_bus_arbiter_pkg
// Shared definitions for the two-master memory bus arbiter:
//   - order_e  : access-size encoding carried on the ORDER fields
//   - owner_t  : one-bit owner ID stored in the in-order tag FIFO
//   - OWNER_M0 / OWNER_M1 : IDs of the fetch and load/store masters
// -----------------------------------------------------------------------------
package memory_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ORDER_BYTE = 2'b00,
    ORDER_HALF = 2'b01,
    ORDER_WORD = 2'b10,
    ORDER_NONE = 2'b11
  } order_e;

  typedef logic owner_t;

  localparam owner_t OWNER_M0 = 1'b0;
  localparam owner_t OWNER_M1 = 1'b1;

endpackage

// File: rtl/memory_bus_arbiter_tag_fifo.sv
// -----------------------------------------------------------------------------
// memory_bus_arbiter_tag_fifo
// In-order FIFO of owner IDs, one entry per outstanding read. The head entry
// names the master that owns the next read return.
// Ports:
//   clock_i, reset_i  : clock and synchronous active-high reset
//   push_i            : store pushOwner_i (ignored when full)
//   pushOwner_i       : owner ID of the accepted read
//   pop_i             : retire the head entry (ignored when empty)
//   headOwner_o       : owner ID at the head
//   full_o, empty_o   : level flags
//   count_o           : number of stored entries, 0..P_DEPTH
// -----------------------------------------------------------------------------
module memory_bus_arbiter_tag_fifo
  import memory_bus_arbiter_pkg::*;
#(
  parameter int P_DEPTH = 4
) (
  input  logic                         clock_i,
  input  logic                         reset_i,
  input  logic                         push_i,
  input  owner_t                       pushOwner_i,
  input  logic                         pop_i,
  output owner_t                       headOwner_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(P_DEPTH+1)-1:0] count_o
);

  localparam int PTR_W = (P_DEPTH > 1) ? $clog2(P_DEPTH) : 1;
  localparam int CNT_W = $clog2(P_DEPTH + 1);

  owner_t             mem_q [P_DEPTH];
  logic [PTR_W-1:0]   wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0]   rdPtr_q, rdPtr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               doPush, doPop;

  assign full_o      = (count_q == CNT_W'(P_DEPTH));
  assign empty_o     = (count_q == '0);
  assign count_o     = count_q;
  assign headOwner_o = mem_q[rdPtr_q];

  assign doPush = push_i && !full_o;
  assign doPop  = pop_i && !empty_o;

  // Depth is a power of two, so the pointers wrap by natural overflow.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (doPush) wrPtr_d = wrPtr_q + PTR_W'(1);
    if (doPop)  rdPtr_d = rdPtr_q + PTR_W'(1);
    case ({doPush, doPop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  // Entry storage needs no reset: an entry is only read after being written.
  always_ff @(posedge clock_i) begin
    if (doPush) mem_q[wrPtr_q] <= pushOwner_i;
  end

endmodule

// File: rtl/memory_bus_arbiter.sv
// -----------------------------------------------------------------------------
// memory_bus_arbiter
// Arbitrates a fetch master (M0) and a load/store master (M1) onto one memory
// request bus with zero-latency grant, and routes in-order read returns back
// to their owner using a tag FIFO.
// Ports:
//   iCLOCK, iRESET_SYNC           : clock, synchronous active-high reset
//   iMx_REQ / oMx_LOCK            : request and "not accepted this cycle"
//   iMx_ORDER/RW/ADDR/DATA        : per-master command fields
//   oMx_VALID/oMx_DATA, iMx_BUSY  : per-master read-return channel
//   oMEMORY_REQ/ORDER/RW/ADDR/DATA, iMEMORY_LOCK : shared request bus
//   iMEMORY_VALID/DATA, oMEMORY_BUSY             : shared return bus
//   oERROR                        : sticky, return seen with no read pending
// Configuration macro:
//   MEMORY_ARB_ROUND_ROBIN_EN defined   -> round-robin between masters
//   MEMORY_ARB_ROUND_ROBIN_EN undefined -> fixed priority, M1 wins
// -----------------------------------------------------------------------------
module memory_bus_arbiter
  import memory_bus_arbiter_pkg::*;
#(
  parameter int P_TAG_DEPTH = 4
) (
  input  logic        iCLOCK,
  input  logic        iRESET_SYNC,
  input  logic        iM0_REQ,
  output logic        oM0_LOCK,
  input  logic [1:0]  iM0_ORDER,
  input  logic        iM0_RW,
  input  logic [31:0] iM0_ADDR,
  input  logic [31:0] iM0_DATA,
  output logic        oM0_VALID,
  output logic [63:0] oM0_DATA,
  input  logic        iM0_BUSY,
  input  logic        iM1_REQ,
  output logic        oM1_LOCK,
  input  logic [1:0]  iM1_ORDER,
  input  logic        iM1_RW,
  input  logic [31:0] iM1_ADDR,
  input  logic [31:0] iM1_DATA,
  output logic        oM1_VALID,
  output logic [63:0] oM1_DATA,
  input  logic        iM1_BUSY,
  output logic        oMEMORY_REQ,
  input  logic        iMEMORY_LOCK,
  output logic [1:0]  oMEMORY_ORDER,
  output logic        oMEMORY_RW,
  output logic [31:0] oMEMORY_ADDR,
  output logic [31:0] oMEMORY_DATA,
  input  logic        iMEMORY_VALID,
  output logic        oMEMORY_BUSY,
  input  logic [63:0] iMEMORY_DATA,
  output logic        oERROR
);

  localparam int CNT_W = $clog2(P_TAG_DEPTH + 1);

  owner_t           grantOwner;
  owner_t           prioOwner;
  owner_t           headOwner;
  logic             eligible0, eligible1;
  logic             memReq, accept;
  logic             tagFull, tagEmpty, tagPush, tagPop;
  logic [CNT_W-1:0] tagCount;
  logic             headBusy;
  logic             error_q, error_d;

  // A read cannot be granted while the tag FIFO is full, but a write from the
  // other master may still go through, so a blocked read drops out of the
  // contest instead of stalling the whole bus.
  always_comb begin
    eligible0  = iM0_REQ && !(!iM0_RW && tagFull);
    eligible1  = iM1_REQ && !(!iM1_RW && tagFull);
    grantOwner = OWNER_M0;
    if (eligible0 && eligible1) grantOwner = prioOwner;
    else if (eligible1)         grantOwner = OWNER_M1;
    memReq = !iRESET_SYNC && (eligible0 || eligible1);
  end

  assign oMEMORY_REQ   = memReq;
  assign oMEMORY_ORDER = (grantOwner == OWNER_M1) ? iM1_ORDER : iM0_ORDER;
  assign oMEMORY_RW    = (grantOwner == OWNER_M1) ? iM1_RW    : iM0_RW;
  assign oMEMORY_ADDR  = (grantOwner == OWNER_M1) ? iM1_ADDR  : iM0_ADDR;
  assign oMEMORY_DATA  = (grantOwner == OWNER_M1) ? iM1_DATA  : iM0_DATA;

  assign accept   = memReq && !iMEMORY_LOCK;
  assign oM0_LOCK = !(accept && (grantOwner == OWNER_M0));
  assign oM1_LOCK = !(accept && (grantOwner == OWNER_M1));
  assign tagPush  = accept && !oMEMORY_RW;

`ifdef MEMORY_ARB_ROUND_ROBIN_EN
  owner_t prio_q, prio_d;

  // Priority moves to the other master only on an accepted grant, so a
  // locked bus keeps offering the same master.
  always_comb begin
    prio_d = prio_q;
    if (accept) prio_d = (grantOwner == OWNER_M0) ? OWNER_M1 : OWNER_M0;
  end

  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) prio_q <= OWNER_M0;
    else             prio_q <= prio_d;
  end

  assign prioOwner = prio_q;
`else
  assign prioOwner = OWNER_M1;
`endif

  memory_bus_arbiter_tag_fifo #(
    .P_DEPTH(P_TAG_DEPTH)
  ) u_tagFifo (
    .clock_i    (iCLOCK),
    .reset_i    (iRESET_SYNC),
    .push_i     (tagPush),
    .pushOwner_i(grantOwner),
    .pop_i      (tagPop),
    .headOwner_o(headOwner),
    .full_o     (tagFull),
    .empty_o    (tagEmpty),
    .count_o    (tagCount)
  );

  // Returns follow the FIFO head; with nothing outstanding the return is
  // dropped and only flagged through oERROR.
  assign headBusy     = (headOwner == OWNER_M1) ? iM1_BUSY : iM0_BUSY;
  assign oMEMORY_BUSY = !iRESET_SYNC && !tagEmpty && headBusy;
  assign oM0_VALID    = !iRESET_SYNC && iMEMORY_VALID && !tagEmpty && (headOwner == OWNER_M0);
  assign oM1_VALID    = !iRESET_SYNC && iMEMORY_VALID && !tagEmpty && (headOwner == OWNER_M1);
  assign oM0_DATA     = iMEMORY_DATA;
  assign oM1_DATA     = iMEMORY_DATA;
  assign tagPop       = iMEMORY_VALID && !tagEmpty && !oMEMORY_BUSY;

  always_comb begin
    error_d = error_q;
    if (iMEMORY_VALID && (tagCount == '0)) error_d = 1'b1;
  end

  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) error_q <= 1'b0;
    else             error_q <= error_d;
  end

  assign oERROR = error_q;

endmodule

// File: tb/tb_memory_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_memory_bus_arbiter
// Directed self-checking bench for memory_bus_arbiter. Accepted reads push the
// expected owner onto a scoreboard queue; each read return pops it and checks
// that the data is routed to that master only.
// Follows MEMORY_ARB_ROUND_ROBIN_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_memory_bus_arbiter;
  import memory_bus_arbiter_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        m0Req, m0Rw, m0Busy, m1Req, m1Rw, m1Busy;
  logic [1:0]  m0Order, m1Order;
  logic [31:0] m0Addr, m0Data, m1Addr, m1Data;
  logic        m0Lock, m1Lock, m0Valid, m1Valid;
  logic [63:0] m0RetData, m1RetData;
  logic        memReq, memLock, memRw, memValid, memBusy, error;
  logic [1:0]  memOrder;
  logic [31:0] memAddr, memData;
  logic [63:0] memRetData;

  owner_t expQ[$];
  int     checkCount = 0;
  int     passCount  = 0;
  int     failCount  = 0;

  always #5 clock = ~clock;

  memory_bus_arbiter #(.P_TAG_DEPTH(4)) dut (
    .iCLOCK       (clock),
    .iRESET_SYNC  (reset),
    .iM0_REQ      (m0Req),
    .oM0_LOCK     (m0Lock),
    .iM0_ORDER    (m0Order),
    .iM0_RW       (m0Rw),
    .iM0_ADDR     (m0Addr),
    .iM0_DATA     (m0Data),
    .oM0_VALID    (m0Valid),
    .oM0_DATA     (m0RetData),
    .iM0_BUSY     (m0Busy),
    .iM1_REQ      (m1Req),
    .oM1_LOCK     (m1Lock),
    .iM1_ORDER    (m1Order),
    .iM1_RW       (m1Rw),
    .iM1_ADDR     (m1Addr),
    .iM1_DATA     (m1Data),
    .oM1_VALID    (m1Valid),
    .oM1_DATA     (m1RetData),
    .iM1_BUSY     (m1Busy),
    .oMEMORY_REQ  (memReq),
    .iMEMORY_LOCK (memLock),
    .oMEMORY_ORDER(memOrder),
    .oMEMORY_RW   (memRw),
    .oMEMORY_ADDR (memAddr),
    .oMEMORY_DATA (memData),
    .iMEMORY_VALID(memValid),
    .oMEMORY_BUSY (memBusy),
    .iMEMORY_DATA (memRetData),
    .oERROR       (error)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic r0, input logic w0, input logic [31:0] a0,
                               input logic r1, input logic w1, input logic [31:0] a1);
    m0Req  = r0;
    m0Rw   = w0;
    m0Addr = a0;
    m0Data = a0 ^ 32'h5A5A_0000;
    m1Req  = r1;
    m1Rw   = w1;
    m1Addr = a1;
    m1Data = a1 ^ 32'hA5A5_0000;
    #2;
  endtask

  // Checks the request bus against the expected grant, clocks once, and
  // records an accepted read on the scoreboard.
  task automatic grantStep(input string tag, input logic expReq, input owner_t expOwner);
    logic accepted;
    #2;
    accepted = expReq && !memLock;
    checkOutput({tag, "_req"}, {63'd0, memReq}, {63'd0, expReq});
    if (expReq) begin
      checkOutput({tag, "_addr"},  {32'd0, memAddr},  {32'd0, (expOwner == OWNER_M1) ? m1Addr : m0Addr});
      checkOutput({tag, "_rw"},    {63'd0, memRw},    {63'd0, (expOwner == OWNER_M1) ? m1Rw : m0Rw});
      checkOutput({tag, "_order"}, {62'd0, memOrder}, {62'd0, (expOwner == OWNER_M1) ? m1Order : m0Order});
      checkOutput({tag, "_wdata"}, {32'd0, memData},  {32'd0, (expOwner == OWNER_M1) ? m1Data : m0Data});
    end
    checkOutput({tag, "_lock0"}, {63'd0, m0Lock}, {63'd0, !(accepted && expOwner == OWNER_M0)});
    checkOutput({tag, "_lock1"}, {63'd0, m1Lock}, {63'd0, !(accepted && expOwner == OWNER_M1)});
    if (accepted && !((expOwner == OWNER_M1) ? m1Rw : m0Rw)) expQ.push_back(expOwner);
    tick();
  endtask

  // Presents one read return and checks it reaches only the scoreboard owner.
  task automatic returnCheck(input string tag, input logic [63:0] data);
    owner_t owner;
    memValid   = 1'b1;
    memRetData = data;
    #2;
    if (expQ.size() == 0) begin
      checkCount++;
      failCount++;
      $error("[TB] FAIL %s observed=return expected=no_outstanding_read", tag);
    end else begin
      owner = expQ.pop_front();
      checkOutput({tag, "_v0"},   {63'd0, m0Valid}, {63'd0, owner == OWNER_M0});
      checkOutput({tag, "_v1"},   {63'd0, m1Valid}, {63'd0, owner == OWNER_M1});
      checkOutput({tag, "_busy"}, {63'd0, memBusy}, 64'd0);
      checkOutput({tag, "_data"}, (owner == OWNER_M1) ? m1RetData : m0RetData, data);
    end
    tick();
    memValid = 1'b0;
  endtask

  initial begin
    owner_t expOwn;
    reset      = 1'b1;
    memLock    = 1'b0;
    memValid   = 1'b0;
    memRetData = '0;
    m0Order    = 2'b10;
    m1Order    = 2'b01;
    m0Busy     = 1'b0;
    m1Busy     = 1'b0;
    applyStimulus(0, 0, 32'd0, 0, 0, 32'd0);
    tick();

    // Reset holds the bus quiet even with requests and a stray return present.
    m0Busy   = 1'b1;
    memValid = 1'b1;
    applyStimulus(1, 0, 32'h100, 1, 0, 32'h200);
    checkOutput("rst_req",   {63'd0, memReq},  64'd0);
    checkOutput("rst_lock0", {63'd0, m0Lock},  64'd1);
    checkOutput("rst_lock1", {63'd0, m1Lock},  64'd1);
    checkOutput("rst_v0",    {63'd0, m0Valid}, 64'd0);
    checkOutput("rst_v1",    {63'd0, m1Valid}, 64'd0);
    checkOutput("rst_busy",  {63'd0, memBusy}, 64'd0);
    tick();
    checkOutput("rst_err", {63'd0, error}, 64'd0);
    reset    = 1'b0;
    memValid = 1'b0;
    m0Busy   = 1'b0;
    applyStimulus(0, 0, 32'd0, 0, 0, 32'd0);
    tick();
    checkOutput("rst_err_after", {63'd0, error}, 64'd0);

    // Single M0 read and its return.
    applyStimulus(1, 0, 32'h0000_1000, 0, 0, 32'd0);
    grantStep("t1", 1'b1, OWNER_M0);
    applyStimulus(0, 0, 32'd0, 0, 0, 32'd0);
    returnCheck("t1_ret", 64'h1122_3344_5566_7788);

    // Both masters write every cycle.
    for (int i = 0; i < 4; i++) begin
`ifdef MEMORY_ARB_ROUND_ROBIN_EN
      expOwn = (i % 2 == 0) ? OWNER_M1 : OWNER_M0;
`else
      expOwn = OWNER_M1;
`endif
      applyStimulus(1, 1, 32'h0000_00A0 + 32'(i), 1, 1, 32'h0000_00B0 + 32'(i));
      grantStep("t2", 1'b1, expOwn);
    end
    applyStimulus(0, 0, 32'd0, 0, 0, 32'd0);

    // Fill the tag FIFO with M1 reads; a fifth read must wait, a write must not.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 32'd0, 1, 0, 32'h0000_3000 + 32'(i * 4));
      grantStep("t3_fill", 1'b1, OWNER_M1);
    end
    applyStimulus(0, 0, 32'd0, 1, 0, 32'h0000_3010);
    grantStep("t3_full", 1'b0, OWNER_M1);
    applyStimulus(1, 1, 32'h0002_0000, 1, 0, 32'h0000_3010);
    grantStep("t3_wr", 1'b1, OWNER_M0);
    applyStimulus(0, 0, 32'd0, 1, 0, 32'h0000_3010);
    memValid   = 1'b1;
    memRetData = 64'hD0D0_0000_0000_0000;
    #2;
    checkOutput("t3_popfull_req", {63'd0, memReq}, 64'd0);
    returnCheck("t3_ret0", 64'hD0D0_0000_0000_0000);
    grantStep("t3_refill", 1'b1, OWNER_M1);
    applyStimulus(0, 0, 32'd0, 0, 0, 32'd0);
    for (int i = 1; i < 5; i++) begin
      returnCheck("t3_drain", 64'hD0D0_0000_0000_0000 + 64'(i));
    end

    // Interleaved owners, with M1 stalling its return.
    applyStimulus(1, 0, 32'h0000_4000, 0, 0, 32'd0);
    grantStep("t4_a", 1'b1, OWNER_M0);
    applyStimulus(0, 0, 32'd0, 1, 0, 32'h0000_4004);
    grantStep("t4_b", 1'b1, OWNER_M1);
    applyStimulus(1, 0, 32'h0000_4008, 0, 0, 32'd0);
    grantStep("t4_c", 1'b1, OWNER_M0);
    applyStimulus(0, 0, 32'd0, 0, 0, 32'd0);
    returnCheck("t4_r0", 64'hAAAA_AAAA_0000_0001);
    m1Busy     = 1'b1;
    memValid   = 1'b1;
    memRetData = 64'hBBBB_BBBB_0000_0002;
    #2;
    checkOutput("t4_busy",    {63'd0, memBusy}, 64'd1);
    checkOutput("t4_busy_v1", {63'd0, m1Valid}, 64'd1);
    checkOutput("t4_busy_v0", {63'd0, m0Valid}, 64'd0);
    tick();
    #1;
    checkOutput("t4_hold_v1",   {63'd0, m1Valid}, 64'd1);
    checkOutput("t4_hold_data", m1RetData, 64'hBBBB_BBBB_0000_0002);
    checkOutput("t4_hold_busy", {63'd0, memBusy}, 64'd1);
    m1Busy = 1'b0;
    returnCheck("t4_r1", 64'hBBBB_BBBB_0000_0002);
    returnCheck("t4_r2", 64'hCCCC_CCCC_0000_0003);

    // Memory lock for three cycles keeps M0 waiting on the same grant.
    memLock = 1'b1;
    applyStimulus(1, 0, 32'h0000_5000, 0, 0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      grantStep("t5_lock", 1'b1, OWNER_M0);
    end
    memLock = 1'b0;
    grantStep("t5_go", 1'b1, OWNER_M0);
    applyStimulus(0, 0, 32'd0, 0, 0, 32'd0);
    returnCheck("t5_ret", 64'h5555_5555_5555_5555);

    // A return with nothing outstanding is dropped and flagged.
    m0Busy     = 1'b1;
    memValid   = 1'b1;
    memRetData = 64'hEEEE_0000_0000_0001;
    #2;
    checkOutput("t5_empty_v0",   {63'd0, m0Valid}, 64'd0);
    checkOutput("t5_empty_busy", {63'd0, memBusy}, 64'd0);
    checkOutput("t5_err_before", {63'd0, error},   64'd0);
    tick();
    memValid = 1'b0;
    m0Busy   = 1'b0;
    #1;
    checkOutput("t5_err", {63'd0, error}, 64'd1);

    // Reset clears the flag; reset mid-flight discards outstanding tags.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    checkOutput("t6_err_clr", {63'd0, error}, 64'd0);
    applyStimulus(1, 0, 32'h0000_6000, 0, 0, 32'd0);
    grantStep("t6_a", 1'b1, OWNER_M0);
    applyStimulus(0, 0, 32'd0, 1, 0, 32'h0000_6004);
    grantStep("t6_b", 1'b1, OWNER_M1);
    applyStimulus(0, 0, 32'd0, 0, 0, 32'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    expQ.delete();
    m0Busy     = 1'b1;
    m1Busy     = 1'b1;
    memValid   = 1'b1;
    memRetData = 64'hF00D_F00D_F00D_F00D;
    #2;
    checkOutput("t6_v0",   {63'd0, m0Valid}, 64'd0);
    checkOutput("t6_v1",   {63'd0, m1Valid}, 64'd0);
    checkOutput("t6_busy", {63'd0, memBusy}, 64'd0);
    tick();
    memValid = 1'b0;
    m0Busy   = 1'b0;
    m1Busy   = 1'b0;
    #1;
    checkOutput("t6_err", {63'd0, error}, 64'd1);
    tick();
    checkOutput("t6_err_sticky", {63'd0, error}, 64'd1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
